// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// Optional starvation guard is enabled with the MEM_ARB_STARVE_GUARD_EN macro.
package mem_arb_pkg;

    localparam int DEF_DATA_SIZE    = 32;
    localparam int DEF_ADDRESS_SIZE = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    // Transaction sequencing: accept, drive the RAM, return the response
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Which requester owns the transaction in flight
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

    // RAM read_write encoding
    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and RAM bus seen by the arbiter.
// slave: the arbiter side; master: requesters plus RAM (environment side).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE
);
    logic                    if_req_valid;
    logic [ADDRESS_SIZE-1:0] if_req_addr;
    logic                    if_req_ready;
    logic                    if_rsp_valid;
    logic [DATA_SIZE-1:0]    if_rsp_data;

    logic                    ls_req_valid;
    logic                    ls_req_write;
    logic [ADDRESS_SIZE-1:0] ls_req_addr;
    logic [DATA_SIZE-1:0]    ls_req_wdata;
    logic                    ls_req_ready;
    logic                    ls_rsp_valid;
    logic [DATA_SIZE-1:0]    ls_rsp_data;

    logic                    ram_read_write;
    logic [ADDRESS_SIZE-1:0] ram_address;
    logic [DATA_SIZE-1:0]    ram_data_in;
    logic [DATA_SIZE-1:0]    ram_data_out;

    modport slave (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata,
        input  ram_data_out,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output ram_read_write, ram_address, ram_data_in
    );

    modport master (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata,
        output ram_data_out,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  ram_read_write, ram_address, ram_data_in
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts LS grants made while IF is waiting; forces an IF win at the limit.
// Used only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic idle_i,
    input  logic if_valid_i,
    input  logic if_grant_i,
    input  logic ls_grant_i,
    output logic force_if_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear when IF is served or stops waiting, saturate at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (if_grant_i) begin
            cnt_d = {CW{1'b0}};
        end else if (ls_grant_i && if_valid_i) begin
            if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (idle_i && !if_valid_i) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if_o = (cnt_q == LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port RAM between instruction fetch and load/store.
// One transaction per three cycles; LS has priority unless MEM_ARB_STARVE_GUARD_EN
// is defined, in which case a starved IF is forced through after STARVE_LIMIT LS grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    state_e                  state_q;
    state_e                  state_d;
    gnt_e                    winner_q;
    logic                    write_q;
    logic                    ram_rw_q;
    logic [ADDRESS_SIZE-1:0] ram_addr_q;
    logic [DATA_SIZE-1:0]    ram_wdata_q;
    logic                    if_rsp_valid_q;
    logic [DATA_SIZE-1:0]    if_rsp_data_q;
    logic                    ls_rsp_valid_q;
    logic [DATA_SIZE-1:0]    ls_rsp_data_q;

    logic grant_if_s;
    logic grant_ls_s;
    logic force_if_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .idle_i     (state_q == ST_IDLE),
        .if_valid_i (bus.if_req_valid),
        .if_grant_i (grant_if_s),
        .ls_grant_i (grant_ls_s),
        .force_if_o (force_if_s)
    );
`else
    assign force_if_s = 1'b0;
`endif

    // Arbitration: only in IDLE and out of reset; LS wins unless IF is being forced
    always_comb begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
        if (reset_n && (state_q == ST_IDLE)) begin
            if (bus.if_req_valid && (force_if_s || !bus.ls_req_valid)) begin
                grant_if_s = 1'b1;
            end else if (bus.ls_req_valid) begin
                grant_ls_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
                grant_ls_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_ls_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if_s || grant_ls_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch the winner's request at accept, capture read data at end of ACCESS
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            winner_q       <= GNT_IF;
            write_q        <= 1'b0;
            ram_rw_q       <= RAM_READ;
            ram_addr_q     <= {ADDRESS_SIZE{1'b0}};
            ram_wdata_q    <= {DATA_SIZE{1'b0}};
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= {DATA_SIZE{1'b0}};
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= {DATA_SIZE{1'b0}};
        end else begin
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_ls_s) begin
                        winner_q   <= GNT_LS;
                        write_q    <= bus.ls_req_write;
                        ram_addr_q <= bus.ls_req_addr;
                        ram_rw_q   <= bus.ls_req_write ? RAM_WRITE : RAM_READ;
                        if (bus.ls_req_write) begin
                            ram_wdata_q <= bus.ls_req_wdata;
                        end
                    end else if (grant_if_s) begin
                        winner_q   <= GNT_IF;
                        write_q    <= 1'b0;
                        ram_addr_q <= bus.if_req_addr;
                        ram_rw_q   <= RAM_READ;
                    end else begin
                        ram_rw_q <= RAM_READ;
                    end
                end
                ST_ACCESS: begin
                    ram_rw_q <= RAM_READ;
                    if (winner_q == GNT_LS) begin
                        ls_rsp_valid_q <= 1'b1;
                        ls_rsp_data_q  <= write_q ? {DATA_SIZE{1'b0}} : bus.ram_data_out;
                    end else begin
                        if_rsp_valid_q <= 1'b1;
                        if_rsp_data_q  <= bus.ram_data_out;
                    end
                end
                ST_RESP: begin
                    ram_rw_q <= RAM_READ;
                end
                default: begin
                    ram_rw_q <= RAM_READ;
                end
            endcase
        end
    end

    assign bus.if_req_ready   = grant_if_s;
    assign bus.ls_req_ready   = grant_ls_s;
    assign bus.if_rsp_valid   = if_rsp_valid_q;
    assign bus.if_rsp_data    = if_rsp_data_q;
    assign bus.ls_rsp_valid   = ls_rsp_valid_q;
    assign bus.ls_rsp_data    = ls_rsp_data_q;
    // Reset forces a read so a store abandoned mid-ACCESS never reaches the RAM
    assign bus.ram_read_write = ram_rw_q | ~reset_n;
    assign bus.ram_address    = ram_addr_q;
    assign bus.ram_data_in    = ram_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_data;
    logic [31:0] mem [0:65535];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge; bench preload port has precedence
    assign bus.ram_data_out = mem[bus.ram_address];
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (bus.ram_read_write == 1'b0) mem[bus.ram_address] <= bus.ram_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        cyc();
        tb_we   = 1'b0;
    endtask

    task automatic idle_bus();
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 16'h0000;
        bus.ls_req_valid = 1'b0;
        bus.ls_req_write = 1'b0;
        bus.ls_req_addr  = 16'h0000;
        bus.ls_req_wdata = 32'h0000_0000;
    endtask

    initial begin
        logic exp_if;
        tests   = 0;
        fails   = 0;
        tb_we   = 1'b0;
        tb_addr = 16'h0000;
        tb_data = 32'h0000_0000;
        idle_bus();
        reset_n = 1'b0;
        cyc();
        preload(16'h0010, 32'hE3A0_1005);
        preload(16'h0004, 32'hE1A0_0000);
        preload(16'h0300, 32'hCAFE_F00D);
        preload(16'h0040, 32'hA5A5_A5A5);
        preload(16'h0500, 32'h1111_1111);
        preload(16'h0502, 32'h3333_3333);
        preload(16'h0600, 32'h6666_6666);

        // Reset state
        chk("rst_if_ready",  {31'd0, bus.if_req_ready},   32'd0);
        chk("rst_ls_rspv",   {31'd0, bus.ls_rsp_valid},   32'd0);
        chk("rst_if_rspd",   bus.if_rsp_data,             32'd0);
        chk("rst_rw",        {31'd0, bus.ram_read_write}, 32'd1);
        chk("rst_addr",      {16'd0, bus.ram_address},    32'd0);
        chk("rst_din",       bus.ram_data_in,             32'd0);
        reset_n = 1'b1;
        cyc();

        // 1: IF fetch, ready at N, response at N+2
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 16'h0010;
        #1;
        chk("t1_if_ready", {31'd0, bus.if_req_ready}, 32'd1);
        chk("t1_ls_ready", {31'd0, bus.ls_req_ready}, 32'd0);
        cyc();
        bus.if_req_valid = 1'b0;
        chk("t1_acc_addr", {16'd0, bus.ram_address},    32'h0010);
        chk("t1_acc_rw",   {31'd0, bus.ram_read_write}, 32'd1);
        chk("t1_acc_rspv", {31'd0, bus.if_rsp_valid},   32'd0);
        cyc();
        chk("t1_rspv",     {31'd0, bus.if_rsp_valid},   32'd1);
        chk("t1_rspd",     bus.if_rsp_data,             32'hE3A0_1005);
        chk("t1_ls_rspv",  {31'd0, bus.ls_rsp_valid},   32'd0);
        cyc();
        chk("t1_rspv_end", {31'd0, bus.if_rsp_valid},   32'd0);

        // 2: store then load at 0x0200; wdata change after accept ignored
        bus.ls_req_valid = 1'b1;
        bus.ls_req_write = 1'b1;
        bus.ls_req_addr  = 16'h0200;
        bus.ls_req_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_st_ready", {31'd0, bus.ls_req_ready}, 32'd1);
        cyc();
        bus.ls_req_valid = 1'b0;
        bus.ls_req_wdata = 32'h0BAD_0BAD;
        #1;
        chk("t2_st_rw",    {31'd0, bus.ram_read_write}, 32'd0);
        chk("t2_st_din",   bus.ram_data_in,             32'hDEAD_BEEF);
        chk("t2_st_addr",  {16'd0, bus.ram_address},    32'h0200);
        cyc();
        chk("t2_st_rspv",  {31'd0, bus.ls_rsp_valid},   32'd1);
        chk("t2_st_rspd",  bus.ls_rsp_data,             32'd0);
        chk("t2_st_rw2",   {31'd0, bus.ram_read_write}, 32'd1);
        chk("t2_st_mem",   mem[16'h0200],               32'hDEAD_BEEF);
        cyc();
        bus.ls_req_valid = 1'b1;
        bus.ls_req_write = 1'b0;
        #1;
        chk("t2_ld_ready", {31'd0, bus.ls_req_ready},   32'd1);
        cyc();
        bus.ls_req_valid = 1'b0;
        chk("t2_ld_rw",    {31'd0, bus.ram_read_write}, 32'd1);
        cyc();
        chk("t2_ld_rspv",  {31'd0, bus.ls_rsp_valid},   32'd1);
        chk("t2_ld_rspd",  bus.ls_rsp_data,             32'hDEAD_BEEF);
        chk("t2_if_hold",  bus.if_rsp_data,             32'hE3A0_1005);
        cyc();

        // 3: simultaneous IF and LS; LS first, IF three cycles later
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 16'h0004;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_write = 1'b0;
        bus.ls_req_addr  = 16'h0300;
        #1;
        chk("t3_ls_first", {31'd0, bus.ls_req_ready}, 32'd1);
        chk("t3_if_wait",  {31'd0, bus.if_req_ready}, 32'd0);
        cyc();
        bus.ls_req_valid = 1'b0;
        chk("t3_acc_ifr",  {31'd0, bus.if_req_ready}, 32'd0);
        cyc();
        chk("t3_ls_rspd",  bus.ls_rsp_data,           32'hCAFE_F00D);
        chk("t3_rsp_ifr",  {31'd0, bus.if_req_ready}, 32'd0);
        cyc();
        chk("t3_if_ready", {31'd0, bus.if_req_ready}, 32'd1);
        cyc();
        bus.if_req_valid = 1'b0;
        cyc();
        chk("t3_if_rspv",  {31'd0, bus.if_rsp_valid}, 32'd1);
        chk("t3_if_rspd",  bus.if_rsp_data,           32'hE1A0_0000);
        cyc();

        // 4: LS held continuously with IF waiting
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 16'h0010;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_write = 1'b0;
        bus.ls_req_addr  = 16'h0600;
        for (int k = 0; k < 5; k++) begin
            #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (k == 4);
`else
            exp_if = 1'b0;
`endif
            chk($sformatf("t4_if_gnt%0d", k), {31'd0, bus.if_req_ready}, {31'd0, exp_if});
            chk($sformatf("t4_ls_gnt%0d", k), {31'd0, bus.ls_req_ready}, {31'd0, ~exp_if});
            cyc();
            cyc();
            cyc();
        end
        idle_bus();
        cyc();

        // 5: reset during ACCESS of a store abandons it
        bus.ls_req_valid = 1'b1;
        bus.ls_req_write = 1'b1;
        bus.ls_req_addr  = 16'h0040;
        bus.ls_req_wdata = 32'h1234_5678;
        #1;
        chk("t5_ready",    {31'd0, bus.ls_req_ready},   32'd1);
        cyc();
        bus.ls_req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t5_rw_gated", {31'd0, bus.ram_read_write}, 32'd1);
        cyc();
        chk("t5_rspv",     {31'd0, bus.ls_rsp_valid},   32'd0);
        chk("t5_mem",      mem[16'h0040],               32'hA5A5_A5A5);
        chk("t5_addr",     {16'd0, bus.ram_address},    32'd0);
        chk("t5_din",      bus.ram_data_in,             32'd0);
        chk("t5_lsd",      bus.ls_rsp_data,             32'd0);
        cyc();
        chk("t5_rspv2",    {31'd0, bus.ls_rsp_valid},   32'd0);
        reset_n = 1'b1;
        cyc();

        // 6: back-to-back loads, address changed right after accept
        bus.ls_req_valid = 1'b1;
        bus.ls_req_write = 1'b0;
        bus.ls_req_addr  = 16'h0500;
        #1;
        chk("t6_ready1",   {31'd0, bus.ls_req_ready}, 32'd1);
        cyc();
        bus.ls_req_addr  = 16'h0502;
        #1;
        chk("t6_acc_addr", {16'd0, bus.ram_address},  32'h0500);
        chk("t6_acc_rdy",  {31'd0, bus.ls_req_ready}, 32'd0);
        cyc();
        chk("t6_rspd1",    bus.ls_rsp_data,           32'h1111_1111);
        chk("t6_rsp_rdy",  {31'd0, bus.ls_req_ready}, 32'd0);
        cyc();
        chk("t6_ready2",   {31'd0, bus.ls_req_ready}, 32'd1);
        cyc();
        bus.ls_req_valid = 1'b0;
        chk("t6_acc_addr2", {16'd0, bus.ram_address}, 32'h0502);
        cyc();
        chk("t6_rspv2",    {31'd0, bus.ls_rsp_valid}, 32'd1);
        chk("t6_rspd2",    bus.ls_rsp_data,           32'h3333_3333);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
